// File: rtl/sawtooth_pkg.sv
// Shared definitions for the sawtooth decoder: FSM state encoding, default
// sizing and the nominal number of staircase steps per sawtooth period.
// Optional feature macro: SAWTOOTH_DECODER_LOCK_EN (adds the LOCKED state).
package sawtooth_pkg;

   localparam int SAMPLE_WIDTH     = 8;
   localparam int DEF_COUNT_WIDTH  = 8;
   localparam int DEF_WRAP_THRESH  = 64;
   localparam int STEPS_PER_PERIOD = 16;
   localparam int STEPS_MAX        = 31;

   // LOCKED only exists when lock detection is built in.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1
`ifdef SAWTOOTH_DECODER_LOCK_EN
      ,
      LOCKED  = 2'd2
`endif
   } state_t;

   // Step counter increment that sticks at its maximum instead of rolling over.
   function automatic logic [4:0] stepInc(input logic [4:0] steps);
      return (steps == 5'(STEPS_MAX)) ? steps : steps + 5'd1;
   endfunction

endpackage

// File: rtl/sawtooth_decoder_if.sv
// Bundles the sample stream and the measurement results of the sawtooth
// decoder. The master side produces samples and observes results; the slave
// side is the decoder itself.
// Optional feature macro: SAWTOOTH_DECODER_LOCK_EN (locked is tied low without it).
interface sawtooth_decoder_if
   import sawtooth_pkg::*;
#(
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
);

   logic [SAMPLE_WIDTH-1:0] sample_in;
   logic [COUNT_WIDTH-1:0]  period_out;
   logic [4:0]              steps_out;
   logic                    period_valid;
   logic                    overflow;
   logic                    locked;

   modport master (
      output sample_in,
      input  period_out,
      input  steps_out,
      input  period_valid,
      input  overflow,
      input  locked
   );

   modport slave (
      input  sample_in,
      output period_out,
      output steps_out,
      output period_valid,
      output overflow,
      output locked
   );

endinterface

// File: rtl/sawtooth_edge_detect.sv
// Keeps a one-cycle-delayed copy of the sample stream and flags, for the
// current input, whether it is a sawtooth wrap (a large enough downward jump)
// or merely a change of level. A drop smaller than WRAP_THRESH is just a
// change, so ripple on the ramp is never mistaken for a wrap.
module sawtooth_edge_detect
   import sawtooth_pkg::*;
#(
   parameter int WRAP_THRESH = DEF_WRAP_THRESH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [SAMPLE_WIDTH-1:0] sample_i,
   output logic                    wrap_o,
   output logic                    change_o
);

   // One extra bit so the threshold and the drop never truncate.
   localparam logic [SAMPLE_WIDTH:0] THRESH = (SAMPLE_WIDTH + 1)'(WRAP_THRESH);

   logic [SAMPLE_WIDTH-1:0] sample_q;
   logic [SAMPLE_WIDTH:0]   drop;

   // Previous sample, cleared by reset so the first post-reset sample compares against zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_q <= '0;
      end else begin
         sample_q <= sample_i;
      end
   end

   // Wrap is a downward step of at least the threshold; any difference counts as a change.
   always_comb begin
      drop     = {1'b0, sample_q} - {1'b0, sample_i};
      wrap_o   = (sample_i < sample_q) && (drop >= THRESH);
      change_o = (sample_i != sample_q);
   end

endmodule

// File: rtl/sawtooth_decoder.sv
// Measures the period of a sawtooth sample stream in clock cycles and the
// number of level changes seen within each period. Each wrap closes one
// period and reports it with a one-cycle period_valid pulse. A period longer
// than the counter can express parks the decoder in IDLE with overflow set
// until the next wrap restarts measurement.
// Optional feature macro: SAWTOOTH_DECODER_LOCK_EN -- when defined, two
// consecutive identical periods of exactly STEPS_PER_PERIOD steps put the
// decoder in LOCKED; when undefined, locked is tied low and no history of
// the previous period is kept.
module sawtooth_decoder
   import sawtooth_pkg::*;
#(
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int WRAP_THRESH = DEF_WRAP_THRESH
) (
   input  logic              clk,
   input  logic              reset,
   sawtooth_decoder_if.slave bus
);

   // cnt holds "cycles since wrap minus one", so a saturating step from
   // CNT_SAT to CNT_MAX means the period can no longer be represented.
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_SAT = CNT_MAX - COUNT_WIDTH'(1);

   logic                   wrap;
   logic                   change;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [4:0]             step_q, step_d;
   logic [COUNT_WIDTH-1:0] period_q, period_d;
   logic [4:0]             stepsOut_q, stepsOut_d;
   logic                   valid_q, valid_d;
   logic                   overflow_q, overflow_d;
   logic [COUNT_WIDTH-1:0] periodMeas;

`ifdef SAWTOOTH_DECODER_LOCK_EN
   logic [COUNT_WIDTH-1:0] prevPeriod_q, prevPeriod_d;
   logic                   prevOk_q, prevOk_d;
   logic                   locked_q, locked_d;
   logic                   lockMatch;
`endif

   sawtooth_edge_detect #(
      .WRAP_THRESH (WRAP_THRESH)
   ) u_edge (
      .clk      (clk),
      .reset    (reset),
      .sample_i (bus.sample_in),
      .wrap_o   (wrap),
      .change_o (change)
   );

   // Next-state and datapath updates: IDLE waits for a wrap to start timing,
   // the measuring states report on every wrap and otherwise keep counting.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      step_d     = step_q;
      period_d   = period_q;
      stepsOut_d = stepsOut_q;
      valid_d    = 1'b0;
      overflow_d = overflow_q;
      periodMeas = cnt_q + COUNT_WIDTH'(1);
`ifdef SAWTOOTH_DECODER_LOCK_EN
      prevPeriod_d = prevPeriod_q;
      prevOk_d     = prevOk_q;
      lockMatch    = prevOk_q && (periodMeas == prevPeriod_q)
                     && (step_q == 5'(STEPS_PER_PERIOD));
`endif

      case (state_q)
         IDLE: begin
            if (wrap) begin
               state_d    = MEASURE;
               cnt_d      = '0;
               step_d     = '0;
               overflow_d = 1'b0;
`ifdef SAWTOOTH_DECODER_LOCK_EN
               prevOk_d   = 1'b0;
`endif
            end
         end

         default: begin
            if (wrap) begin
               period_d   = periodMeas;
               stepsOut_d = step_q;
               valid_d    = 1'b1;
               cnt_d      = '0;
               step_d     = '0;
`ifdef SAWTOOTH_DECODER_LOCK_EN
               state_d      = lockMatch ? LOCKED : MEASURE;
               prevPeriod_d = periodMeas;
               prevOk_d     = (step_q == 5'(STEPS_PER_PERIOD));
`else
               state_d      = MEASURE;
`endif
            end else begin
               if (change) begin
                  step_d = stepInc(step_q);
               end
               if (cnt_q == CNT_SAT) begin
                  cnt_d      = CNT_MAX;
                  overflow_d = 1'b1;
                  state_d    = IDLE;
               end else begin
                  cnt_d = cnt_q + COUNT_WIDTH'(1);
               end
            end
         end
      endcase

`ifdef SAWTOOTH_DECODER_LOCK_EN
      locked_d = (state_d == LOCKED);
`endif
   end

   // State and measurement registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         step_q     <= '0;
         period_q   <= '0;
         stepsOut_q <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         period_q   <= period_d;
         stepsOut_q <= stepsOut_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef SAWTOOTH_DECODER_LOCK_EN
   // Previous-period history and the registered lock indicator.
   always_ff @(posedge clk) begin
      if (reset) begin
         prevPeriod_q <= '0;
         prevOk_q     <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         prevPeriod_q <= prevPeriod_d;
         prevOk_q     <= prevOk_d;
         locked_q     <= locked_d;
      end
   end

   assign bus.locked = locked_q;
`else
   assign bus.locked = 1'b0;
`endif

   assign bus.period_out   = period_q;
   assign bus.steps_out    = stepsOut_q;
   assign bus.period_valid = valid_q;
   assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_sawtooth_decoder.sv
// Directed testbench for sawtooth_decoder. The stimulus generator produces a
// 17-level staircase per period: sample = 15 * floor((i+1)*16/N) for
// i = 0..N-1, so each period starts at 0 (the wrap), tops out at 240, and
// contains exactly 16 upward level changes. Expected lock values follow
// SAWTOOTH_DECODER_LOCK_EN.
module tb_sawtooth_decoder;
   import sawtooth_pkg::*;

`ifdef SAWTOOTH_DECODER_LOCK_EN
   localparam logic LOCK_EN = 1'b1;
`else
   localparam logic LOCK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   assertCount = 0;
   int   failCount   = 0;
   int   pulses;

   sawtooth_decoder_if #(.COUNT_WIDTH(8)) bus ();

   sawtooth_decoder #(
      .COUNT_WIDTH (8),
      .WRAP_THRESH (64)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   function automatic logic [7:0] genSample(input int i, input int n);
      return 8'(15 * (((i + 1) * 16) / n));
   endfunction

   // Drive one sample for one cycle; return 1 time unit after the rising edge.
   task automatic applyStimulus(input logic [7:0] s);
      bus.sample_in = s;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic expValid, input int expPeriod,
                           input int expSteps, input logic expOvf, input logic expLocked);
      checkOutput({tag, ".valid"},    32'(bus.period_valid), 32'(expValid));
      checkOutput({tag, ".period"},   32'(bus.period_out),   expPeriod);
      checkOutput({tag, ".steps"},    32'(bus.steps_out),    expSteps);
      checkOutput({tag, ".overflow"}, 32'(bus.overflow),     32'(expOvf));
      checkOutput({tag, ".locked"},   32'(bus.locked),       32'(expLocked));
   endtask

   // One generator period of n cycles: check the result of its first (wrap)
   // sample, then require no period_valid pulse during the rest of the ramp.
   task automatic genPeriod(input int n, input string tag, input logic expValid,
                            input int expPeriod, input int expSteps, input logic expLocked);
      int gap;
      gap = 0;
      applyStimulus(genSample(0, n));
      checkAll(tag, expValid, expPeriod, expSteps, 1'b0, expLocked);
      for (int i = 1; i < n; i++) begin
         applyStimulus(genSample(i, n));
         if (bus.period_valid === 1'b1) gap++;
      end
      checkOutput({tag, ".gap"}, gap, 0);
   endtask

   initial begin
      reset         = 1'b1;
      bus.sample_in = 8'h00;
      applyStimulus(8'hAA);
      applyStimulus(8'hAA);
      checkAll("reset", 1'b0, 0, 0, 1'b0, 1'b0);
      reset = 1'b0;

      // Stable 64-cycle sawtooth, then a switch to 128 and back.
      genPeriod(64,  "prime",  1'b0, 0,   0,  1'b0);
      genPeriod(64,  "wrap1",  1'b0, 0,   0,  1'b0);
      genPeriod(64,  "wrap2",  1'b1, 64,  16, 1'b0);
      genPeriod(64,  "wrap3",  1'b1, 64,  16, LOCK_EN);
      genPeriod(128, "p64b",   1'b1, 64,  16, LOCK_EN);
      genPeriod(128, "p128a",  1'b1, 128, 16, 1'b0);
      genPeriod(64,  "p128b",  1'b1, 128, 16, LOCK_EN);

      // Wrap closing the last 64-cycle period: differs from 128, lock drops.
      applyStimulus(8'h00);
      checkAll("ret64", 1'b1, 64, 16, 1'b0, 1'b0);

      // Drop of 32 is only a change, not a wrap.
      applyStimulus(8'hF0);
      applyStimulus(8'hD0);
      checkOutput("drop32.valid", 32'(bus.period_valid), 0);
      repeat (7) applyStimulus(8'hD0);
      applyStimulus(8'h00);
      checkAll("p10", 1'b1, 10, 2, 1'b0, 1'b0);

      // Threshold boundary: drop of 63 is not a wrap, drop of 64 is.
      applyStimulus(8'h40);
      applyStimulus(8'h01);
      checkOutput("drop63.valid", 32'(bus.period_valid), 0);
      applyStimulus(8'h41);
      applyStimulus(8'h01);
      checkAll("drop64", 1'b1, 4, 3, 1'b0, 1'b0);

      // 40 changes in one period saturate the step count at 31.
      for (int t = 1; t <= 40; t++) applyStimulus(8'(1 + 3 * t));
      applyStimulus(8'h00);
      checkAll("sat31", 1'b1, 41, 31, 1'b0, 1'b0);

      // Longest representable period: wrap coincides with counter saturation.
      repeat (254) applyStimulus(8'h80);
      checkOutput("p255.preOvf", 32'(bus.overflow), 0);
      applyStimulus(8'h00);
      checkAll("p255", 1'b1, 255, 1, 1'b0, 1'b0);

      // Constant input for 300 cycles: overflow once cnt reaches 255.
      pulses = 0;
      for (int t = 1; t <= 254; t++) begin
         applyStimulus(8'h80);
         if (bus.period_valid === 1'b1) pulses++;
      end
      checkOutput("ovf.before", 32'(bus.overflow), 0);
      applyStimulus(8'h80);
      checkOutput("ovf.set", 32'(bus.overflow), 1);
      for (int t = 256; t <= 300; t++) begin
         applyStimulus(8'h80);
         if (bus.period_valid === 1'b1) pulses++;
      end
      checkAll("ovf.held", 1'b0, 255, 1, 1'b1, 1'b0);
      checkOutput("ovf.pulses", pulses, 0);

      // Wrap after overflow restarts measurement silently and clears overflow.
      applyStimulus(8'h00);
      checkAll("idleWrap", 1'b0, 255, 1, 1'b0, 1'b0);
      repeat (19) applyStimulus(8'h80);
      applyStimulus(8'h00);
      checkAll("p20", 1'b1, 20, 1, 1'b0, 1'b0);

      // One-cycle reset mid-period discards the partial measurement.
      repeat (5) applyStimulus(8'h80);
      reset = 1'b1;
      applyStimulus(8'h80);
      checkAll("midReset", 1'b0, 0, 0, 1'b0, 1'b0);
      reset = 1'b0;
      repeat (3) applyStimulus(8'h80);
      applyStimulus(8'h00);
      checkAll("postResetWrap", 1'b0, 0, 0, 1'b0, 1'b0);
      repeat (29) applyStimulus(8'h80);
      applyStimulus(8'h00);
      checkAll("p30", 1'b1, 30, 1, 1'b0, 1'b0);
      applyStimulus(8'h80);
      checkOutput("p30.pulseEnd", 32'(bus.period_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/sawtooth_decoder.md
SAWTOOTH_DECODER -- requirements
Module: sawtooth_decoder

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 8, giving the period counter width (equal to the generator's frequency-control width).
REQ-002 SHALL have parameter WRAP_THRESH, default 64, giving the minimum sample drop counted as a wrap.
REQ-003 SHALL have port clk, input, 1 bit: system clock, single clock domain.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sample_in, input, 8 bits: sawtooth sample stream, unsigned.
REQ-006 SHALL have port period_out, output, COUNT_WIDTH bits: last measured period in clk cycles.
REQ-007 SHALL have port steps_out, output, 5 bits: distinct sample changes in the last period, saturating at 31.
REQ-008 SHALL have port period_valid, output, 1 bit: one-cycle pulse when period_out/steps_out update.
REQ-009 SHALL have port overflow, output, 1 bit: period exceeded counter range.
REQ-010 SHALL have port locked, output, 1 bit: stable sawtooth recognised.

Function
REQ-011 SHALL register sample_in into sample_q every cycle.
REQ-012 SHALL flag a wrap in cycle t when sample_q - sample_in >= WRAP_THRESH with sample_in < sample_q; increases and smaller drops are not wraps.
REQ-013 SHALL have FSM states IDLE, MEASURE, LOCKED.
REQ-014 IDLE: on wrap, go to MEASURE and clear cnt and step count; emit no period_valid.
REQ-015 Counting: cnt increments by 1 every cycle; step count increments when sample_in != sample_q and no wrap occurs.
REQ-016 On wrap in MEASURE or LOCKED: period_out <= cnt+1 and steps_out <= step count, with period_valid high the next cycle (1-cycle latency); then clear cnt and step count.
REQ-017 Wraps N cycles apart SHALL yield period_out == N.
REQ-018 If cnt reaches all-ones without a wrap, it SHALL hold there; overflow SHALL be set, locked cleared, and the FSM SHALL enter IDLE; period_out SHALL keep its last value.
REQ-019 overflow SHALL clear on the next wrap, which is treated as an IDLE wrap (REQ-014).
REQ-020 MEASURE -> LOCKED when two consecutive measured periods are equal and both have steps_out == 16.
REQ-021 LOCKED -> MEASURE on a period differing from the previous one or steps_out != 16; locked deasserts in the same cycle period_valid pulses.
REQ-022 locked SHALL equal (state == LOCKED), registered.
REQ-023 Wrap coincident with counter saturation: the wrap takes priority; measure normally, with period_out = all-ones.

Reset
REQ-024 reset SHALL force state IDLE, sample_q = 0, cnt = 0, step count = 0, period_out = 0, steps_out = 0, period_valid = 0, overflow = 0, locked = 0.
REQ-025 reset mid-measurement SHALL discard the partial period; the first post-reset wrap is an IDLE wrap.

Configuration
REQ-026 With macro SAWTOOTH_DECODER_LOCK_EN defined, LOCKED state and lock comparison SHALL be built as above.
REQ-027 Without SAWTOOTH_DECODER_LOCK_EN, LOCKED SHALL be absent, locked tied 0, and no previous-period register built; all other behaviour unchanged.

Structure
REQ-028 A shared package sawtooth_pkg SHALL hold the FSM state encoding, STEPS_PER_PERIOD = 16, and default COUNT_WIDTH = 8 and WRAP_THRESH = 64.
REQ-029 Wrap/change detection SHALL be a sub-module sawtooth_edge_detect (sample_q register, wrap and change flags).

Verification
REQ-030 Generator with frequency_control = 64 driving sample_in, after 3 wraps -> period_out = 64, steps_out = 16, locked = 1 (macro on).
REQ-031 Constant sample_in = 8'h80 for 300 cycles after one wrap (COUNT_WIDTH = 8) -> overflow = 1 at cnt = 255, state IDLE, locked = 0.
REQ-032 Drop 8'hF0 -> 8'hD0 (32 < 64) -> no wrap, no period_valid.
REQ-033 Locked at period 64, then frequency_control switched to 128 -> locked falls with the first period_valid showing 128, and rises again after the second matching 128 period.
REQ-034 reset asserted for one cycle mid-period -> all outputs 0; the next wrap produces no period_valid; the following wrap reports the correct period.
REQ-035 Macro undefined, stable 64-cycle sawtooth -> period_out = 64, period_valid pulses every 64 cycles, locked stays 0.
